// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam int unsigned N_LEGAL_BLOCK = 3;
  localparam int unsigned LEGAL_BLOCK [N_LEGAL_BLOCK] = '{2, 4, 8};

  function automatic bit is_legal_block(input int unsigned blk);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL_BLOCK; i++) begin
      if (LEGAL_BLOCK[i] == blk) ok = 1'b1;
    end
    return ok;
  endfunction

  // Carry into position n as a flat sum of products (no ripple chain).
  function automatic logic lookahead_carry(input logic [63:0] g, input logic [63:0] p,
                                           input logic cin, input int n);
    logic acc;
    logic term;
    acc = cin;
    for (int m = 0; m < n; m++) acc = acc & p[m];
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int m = j + 1; m < n; m++) term = term & p[m];
      acc = acc | term;
    end
    return acc;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One BLOCK-bit lookahead group: bit G/P in, group G/P and per-bit carries out.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] bit_g,
  input  logic [BLOCK-1:0] bit_p,
  input  logic             cin,
  output gp_t              grp,
  output logic [BLOCK-1:0] carry
);

  always_comb begin
    carry = '0;
    for (int i = 0; i < BLOCK; i++) begin
      carry[i] = lookahead_carry(64'(bit_g), 64'(bit_p), cin, i);
    end
    grp.g = lookahead_carry(64'(bit_g), 64'(bit_p), 1'b0, BLOCK);
    grp.p = &bit_p;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready handshake on both sides.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NG = WIDTH / BLOCK;

  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "pipelined_cla_adder: WIDTH must be in 4..64");
  end
  if (!is_legal_block(BLOCK)) begin : g_bad_block
    $fatal(1, "pipelined_cla_adder: BLOCK must be 2, 4 or 8");
  end
  if ((WIDTH % BLOCK) != 0) begin : g_bad_multiple
    $fatal(1, "pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  gp_t  [NG-1:0]    s1_gp_q, s1_gp_d;
  logic             s1_cin_q, s1_cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] b_eff, g_new, p_new;
  gp_t  [NG-1:0]    gp_new;
  logic [NG-1:0]    s1_grp_g, s1_grp_p;
  logic [NG:0]      gcarry;
  logic [WIDTH-1:0] carry_all;
  gp_t  [NG-1:0]    grp_recalc;
  logic             unused_grp;

  always_comb begin
    s2_adv = !out_valid_q | out_ready;
    s1_adv = !s1_valid_q | s2_adv;
  end

  assign in_ready = s1_adv;

  // Stage 1: operand conditioning and bit/group generate-propagate.
  always_comb begin
    b_eff  = in_sub ? ~in_b : in_b;
    g_new  = in_a & b_eff;
    p_new  = in_a ^ b_eff;
    gp_new = '0;
    for (int k = 0; k < NG; k++) begin
      gp_new[k].g = lookahead_carry(64'(g_new[k*BLOCK +: BLOCK]),
                                    64'(p_new[k*BLOCK +: BLOCK]), 1'b0, BLOCK);
      gp_new[k].p = &p_new[k*BLOCK +: BLOCK];
    end
  end

  always_comb begin
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_gp_d    = s1_gp_q;
    s1_cin_d   = s1_cin_q;
    if (s1_adv && in_valid) begin
      s1_g_d   = g_new;
      s1_p_d   = p_new;
      s1_gp_d  = gp_new;
      s1_cin_d = in_sub | in_cin;
    end
  end

  // Stage 2: second-level lookahead across groups feeds each group's carry-in.
  always_comb begin
    s1_grp_g = '0;
    s1_grp_p = '0;
    gcarry   = '0;
    for (int k = 0; k < NG; k++) begin
      s1_grp_g[k] = s1_gp_q[k].g;
      s1_grp_p[k] = s1_gp_q[k].p;
    end
    for (int k = 0; k <= NG; k++) begin
      gcarry[k] = lookahead_carry(64'(s1_grp_g), 64'(s1_grp_p), s1_cin_q, k);
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.BLOCK(BLOCK)) u_grp (
      .bit_g (s1_g_q[k*BLOCK +: BLOCK]),
      .bit_p (s1_p_q[k*BLOCK +: BLOCK]),
      .cin   (gcarry[k]),
      .grp   (grp_recalc[k]),
      .carry (carry_all[k*BLOCK +: BLOCK])
    );
  end

  // Group G/P already travels registered from stage 1; the recomputed copy is not needed here.
  assign unused_grp = ^grp_recalc;

  always_comb begin
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    if (s2_adv && s1_valid_q) begin
      out_sum_d  = s1_p_q ^ carry_all;
      out_cout_d = gcarry[NG];
      out_ovf_d  = carry_all[WIDTH-1] ^ gcarry[NG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_g_q      <= '0;
      s1_p_q      <= '0;
      s1_gp_q     <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_g_q      <= s1_g_d;
      s1_p_q      <= s1_p_d;
      s1_gp_q     <= s1_gp_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomized checks of pipelined_cla_adder at 32/4, 12/4 and 64/8.
module tb_pipelined_cla_adder;

  localparam int N_RND = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v32, r32, ov32, ordy32, cin32, sub32, co32, of32;
  logic [31:0] a32, b32, s32;
  logic        v12, r12, ov12, ordy12, cin12, sub12, co12, of12;
  logic [11:0] a12, b12, s12;
  logic        v64, r64, ov64, ordy64, cin64, sub64, co64, of64;
  logic [63:0] a64, b64, s64;

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(4)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(ov32), .out_ready(ordy32),
    .out_sum(s32), .out_cout(co32), .out_ovf(of32));

  pipelined_cla_adder #(.WIDTH(12), .BLOCK(4)) u_d12 (
    .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(r12), .in_a(a12), .in_b(b12),
    .in_cin(cin12), .in_sub(sub12), .out_valid(ov12), .out_ready(ordy12),
    .out_sum(s12), .out_cout(co12), .out_ovf(of12));

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(8)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in_a(a64), .in_b(b64),
    .in_cin(cin64), .in_sub(sub64), .out_valid(ov64), .out_ready(ordy64),
    .out_sum(s64), .out_cout(co64), .out_ovf(of64));

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {ovf, cout, sum}.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, am, bb, sum;
    logic [64:0] full;
    logic        ci, cout, ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, bb} + {64'd0, ci};
    sum  = full[63:0] & mask;
    cout = full[w];
    ovf  = (am[w-1] == bb[w-1]) && (sum[w-1] != am[w-1]);
    return {ovf, cout, sum};
  endfunction

  function automatic logic [65:0] obs32();
    return {of32, co32, 32'd0, s32};
  endfunction

  task automatic single32(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [65:0] exp);
    @(negedge clk);
    v32 = 1'b1; a32 = a; b32 = b; cin32 = cin; sub32 = sub; ordy32 = 1'b1;
    #1 check({tag, "_in_ready"}, 66'(r32), 66'd1);
    @(negedge clk);
    v32 = 1'b0; a32 = $urandom(); b32 = $urandom(); cin32 = 1'($urandom()); sub32 = 1'($urandom());
    #1 check({tag, "_lat1"}, 66'(ov32), 66'd0);
    @(negedge clk);
    #1 check({tag, "_lat2"}, 66'(ov32), 66'd1);
    check(tag, obs32(), exp);
    @(negedge clk);
    #1 check({tag, "_drain"}, 66'(ov32), 66'd0);
  endtask

  logic [65:0] q32[$];
  logic [65:0] q12[$];
  logic [65:0] q64[$];

  initial begin
    int acc, got, seen;
    int acc12, got12, acc64, got64;

    rst_n = 1'b0;
    v32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; ordy32 = 0;
    v12 = 0; a12 = 0; b12 = 0; cin12 = 0; sub12 = 0; ordy12 = 0;
    v64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; ordy64 = 0;

    #1;
    check("rst_out_valid", 66'(ov32), 66'd0);
    check("rst_out_data", obs32(), 66'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready32", 66'(r32), 66'd1);
    check("rst_in_ready12", 66'(r12), 66'd1);
    check("rst_in_ready64", 66'(r64), 66'd1);

    single32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 64'h0});
    single32("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 64'h8000_0000});
    single32("add_cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 64'h1});
    single32("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFE});
    single32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7FFF_FFFF});

    // Back-pressure: five operand sets, consumer stalled for the first four cycles.
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      ordy32 = (cyc >= 4);
      v32 = (acc < 5);
      a32 = $urandom(); b32 = $urandom(); cin32 = 1'($urandom()); sub32 = 1'($urandom());
      #1;
      if (cyc == 2) begin
        check("bp_in_ready_low", 66'(r32), 66'd0);
        check("bp_accepted", 66'(acc), 66'd2);
      end
      if (cyc == 3) begin
        check("bp_hold_valid", 66'(ov32), 66'd1);
        check("bp_hold_data", obs32(), q32[0]);
      end
      if (ov32 && ordy32) begin
        if (q32.size() == 0) check("bp_extra", 66'(ov32), 66'd0);
        else check("bp_order", obs32(), q32.pop_front());
        got++;
      end
      if (v32 && r32) begin
        q32.push_back(model(32, 64'(a32), 64'(b32), cin32, sub32));
        acc++;
      end
    end
    v32 = 1'b0;
    check("bp_delivered", 66'(got), 66'd5);

    // Reset with two sets in flight.
    @(negedge clk);
    ordy32 = 1'b0; v32 = 1'b1; a32 = $urandom(); b32 = $urandom();
    @(negedge clk);
    a32 = $urandom(); b32 = $urandom();
    @(negedge clk);
    v32 = 1'b0;
    #1 check("mid_pre_valid", 66'(ov32), 66'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 66'(ov32), 66'd0);
    check("mid_rst_data", obs32(), 66'd0);
    #1 rst_n = 1'b1;
    ordy32 = 1'b1;
    #0.5 check("mid_rel_ready", 66'(r32), 66'd1);
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #1 if (ov32) seen++;
    end
    check("mid_no_results", 66'(seen), 66'd0);

    // Random traffic on the 12/4 and 64/8 instances.
    acc12 = 0; got12 = 0; acc64 = 0; got64 = 0;
    for (int cyc = 0; cyc < 60000 && (got12 < N_RND || got64 < N_RND); cyc++) begin
      @(negedge clk);
      ordy12 = ($urandom_range(3) != 0);
      v12    = (acc12 < N_RND) && ($urandom_range(3) != 0);
      a12    = 12'($urandom());
      b12    = ($urandom_range(7) == 0) ? ~a12 : 12'($urandom());
      cin12  = 1'($urandom()); sub12 = 1'($urandom());
      ordy64 = ($urandom_range(3) != 0);
      v64    = (acc64 < N_RND) && ($urandom_range(3) != 0);
      a64    = {$urandom(), $urandom()};
      b64    = ($urandom_range(7) == 0) ? ~a64 : {$urandom(), $urandom()};
      cin64  = 1'($urandom()); sub64 = 1'($urandom());
      #1;
      if (ov12 && ordy12) begin
        if (q12.size() == 0) check("rnd12_extra", 66'(ov12), 66'd0);
        else check("rnd12", {of12, co12, 52'd0, s12}, q12.pop_front());
        got12++;
      end
      if (v12 && r12) begin
        q12.push_back(model(12, 64'(a12), 64'(b12), cin12, sub12));
        acc12++;
      end
      if (ov64 && ordy64) begin
        if (q64.size() == 0) check("rnd64_extra", 66'(ov64), 66'd0);
        else check("rnd64", {of64, co64, s64}, q64.pop_front());
        got64++;
      end
      if (v64 && r64) begin
        q64.push_back(model(64, a64, b64, cin64, sub64));
        acc64++;
      end
    end
    v12 = 1'b0; v64 = 1'b0;
    check("rnd12_count", 66'(got12), 66'(N_RND));
    check("rnd64_count", 66'(got64), 66'(N_RND));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and sum width; legal range 4..64.
REQ-002 The block SHALL have parameter BLOCK, default 4, lookahead group size; legal values 2, 4, 8.
REQ-003 Elaboration SHALL fail when WIDTH is not a multiple of BLOCK.
REQ-004 clk  input  1  single clock; all state is rising-edge triggered.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts the operand set this cycle.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_cin  input  1  carry-in, add mode only.
REQ-011 in_sub  input  1  1 = subtract (A - B), 0 = add.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 out_sum  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-015 out_cout  output  1  carry out of MSB (in subtract mode: 1 = no borrow).
REQ-016 out_ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Add: result = A + B + in_cin; subtract: result = A + ~B + 1, with in_cin ignored.
REQ-018 out_ovf SHALL equal carry into bit WIDTH-1 XOR out_cout.
REQ-019 Stage 1 SHALL register, per bit, G = a & b' and P = a ^ b' (b' = B or ~B); per group, group-G/group-P; and the effective carry-in.
REQ-020 Stage 2 SHALL compute group carries by lookahead over registered group-G/P, then intra-group carries and sum bits, and register sum, cout, ovf.
REQ-021 No ripple path SHALL exceed BLOCK bits; the carry path across groups SHALL be two-level lookahead, not ripple.
REQ-022 A transfer occurs on a rising edge with in_valid & in_ready; likewise on the output side with out_valid & out_ready.
REQ-023 With out_ready held high, latency SHALL be exactly 2 cycles (out_valid high in the cycle after the second edge following acceptance), and throughput SHALL be 1 result per cycle.
REQ-024 Stage-2 advance = !out_valid | out_ready; stage-1 advance = !s1_valid | stage-2 advance; in_ready = stage-1 advance. A combinational out_ready-to-in_ready path is permitted.
REQ-025 While out_valid & !out_ready, out_sum, out_cout and out_ovf SHALL stay stable and out_valid SHALL stay high.
REQ-026 With both stages full and out_ready low, in_ready SHALL be 0; no operand set SHALL be dropped or duplicated, and results SHALL leave in acceptance order.
REQ-027 Simultaneous output take and input accept on a full pipe SHALL shift both stages in the same cycle, with no bubble.
REQ-028 in_a, in_b, in_cin and in_sub SHALL be ignored when in_valid is low.

Reset
REQ-029 rst_n low SHALL immediately clear the stage valid flags; out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, and stage-1 data registers = 0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-031 Reset mid-operation SHALL discard all in-flight results; none SHALL appear after release.

Structure
REQ-032 Shared package cla_pkg SHALL hold the gp_t struct {g, p} and the legal-BLOCK constant list.
REQ-033 Sub-module cla_group (BLOCK-bit lookahead: bit G/P in, group G/P and intra-group carries out) SHALL be instantiated WIDTH/BLOCK times.

Verification
REQ-034 WIDTH=32/BLOCK=4, add 0xFFFFFFFF + 0x00000001, cin=0 -> sum 0x00000000, cout 1, ovf 0, out_valid exactly 2 cycles after accept.
REQ-035 Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout 0, ovf 1; add 0x00000000 + 0x00000000, cin=1 -> sum 0x00000001.
REQ-036 Subtract 5 - 7, cin=1 -> sum 0xFFFFFFFE, cout 0, ovf 0 (cin ignored); subtract 0x80000000 - 1 -> sum 0x7FFFFFFF, cout 1, ovf 1.
REQ-037 Five back-to-back inputs with out_ready low for 4 cycles -> in_ready low after 2 accepted; all 5 results delivered in order with no loss.
REQ-038 Two operand sets in flight, pulse rst_n low mid-cycle -> out_valid drops asynchronously; zero results after release; in_ready = 1.
REQ-039 10k random operands with random in_valid/out_ready at WIDTH=12/BLOCK=4 and WIDTH=64/BLOCK=8 -> sum, cout and ovf match the reference model exactly.
